// File: rtl/ex_stage_md.sv
// DLX execute stage: ALU, branch resolution, and an iterative radix-2 multiply/divide unit that stalls upstream while busy.
// ALU opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, others ADD. Define DLX_EX_SIGNED_MD_EN for signed DIV/REM.
module ex_stage_md #(
    parameter int XLEN = 32,
    parameter int RW   = 5,
    parameter int OPW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_EX,
    input  logic [OPW-1:0]  I_EX,
    input  logic [1:0]      md_op_EX,
    input  logic [1:0]      br_EX,
    input  logic            Pc_alu_EX,
    input  logic            Iv_alu_EX,
    input  logic            d_write_enable_EX,
    input  logic            d_load_enable_EX,
    input  logic [RW-1:0]   Rd_EX,
    input  logic [XLEN-1:0] S1_EX,
    input  logic [XLEN-1:0] S2_EX,
    input  logic [XLEN-1:0] Iv_EX,
    input  logic [XLEN-1:0] PC_EX,
    input  logic            hold_MEM,
    input  logic            flush_EX,
    output logic            stall_EX,
    output logic            pc_cmd_EX,
    output logic [XLEN-1:0] pc_in_EX,
    output logic            valid_MEM,
    output logic [XLEN-1:0] ALU_out_MEM,
    output logic            d_write_enable_MEM,
    output logic            d_load_enable_MEM,
    output logic [RW-1:0]   Rd_MEM
);
    localparam int CW = $clog2(XLEN + 1);
    localparam int SW = $clog2(XLEN);

    localparam logic [OPW-1:0] ALU_SUB  = OPW'(1);
    localparam logic [OPW-1:0] ALU_AND  = OPW'(2);
    localparam logic [OPW-1:0] ALU_OR   = OPW'(3);
    localparam logic [OPW-1:0] ALU_XOR  = OPW'(4);
    localparam logic [OPW-1:0] ALU_SLL  = OPW'(5);
    localparam logic [OPW-1:0] ALU_SRL  = OPW'(6);
    localparam logic [OPW-1:0] ALU_SRA  = OPW'(7);
    localparam logic [OPW-1:0] ALU_SLT  = OPW'(8);
    localparam logic [OPW-1:0] ALU_SLTU = OPW'(9);

    localparam logic [1:0] MD_MUL = 2'b01;
    localparam logic [1:0] MD_DIV = 2'b10;
    localparam logic [1:0] MD_REM = 2'b11;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [1:0]      md_op_reg;
    logic [XLEN-1:0] a_reg;    // multiplier, then dividend/quotient
    logic [XLEN-1:0] b_reg;    // multiplicand or divisor
    logic [XLEN-1:0] acc_reg;  // product or partial remainder

    logic [XLEN-1:0] op1, op2, alu_res;
    logic [XLEN-1:0] op1_mag, op2_mag, md_raw, md_result;
    logic [XLEN:0]   trial;
    logic [SW-1:0]   shamt;
    logic [1:0]      md_sel;
    logic            zf, cond, accept;

    assign op1   = Pc_alu_EX ? PC_EX : S1_EX;
    assign op2   = Iv_alu_EX ? Iv_EX : S2_EX;
    assign shamt = op2[SW-1:0];

    always_comb begin
        alu_res = op1 + op2;
        case (I_EX)
            ALU_SUB:  alu_res = op1 - op2;
            ALU_AND:  alu_res = op1 & op2;
            ALU_OR:   alu_res = op1 | op2;
            ALU_XOR:  alu_res = op1 ^ op2;
            ALU_SLL:  alu_res = op1 << shamt;
            ALU_SRL:  alu_res = op1 >> shamt;
            ALU_SRA:  alu_res = $signed(op1) >>> shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
            default:  alu_res = op1 + op2;
        endcase
    end

    assign zf = (alu_res == '0);

    // A branch combined with a multiply/divide opcode is illegal and executes as a plain ALU op.
    assign md_sel = (br_EX == 2'b00) ? md_op_EX : 2'b00;

    always_comb begin
        cond = 1'b0;
        case (br_EX)
            2'b01:   cond = zf;
            2'b10:   cond = ~zf;
            2'b11:   cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    assign pc_cmd_EX = valid_EX & ~flush_EX & cond;
    assign pc_in_EX  = PC_EX + Iv_EX;

    assign accept   = (state_reg == IDLE) & valid_EX & (md_sel != 2'b00) & ~flush_EX;
    assign stall_EX = accept | (state_reg == BUSY) | ((state_reg == DONE) & hold_MEM);

    // Restoring-division trial subtract; bit XLEN is the borrow.
    assign trial  = {acc_reg, a_reg[XLEN-1]} - {1'b0, b_reg};
    assign md_raw = (md_op_reg == MD_DIV) ? a_reg : acc_reg;

`ifdef DLX_EX_SIGNED_MD_EN
    logic neg_reg;
    logic neg_next;
    assign op1_mag   = (md_sel[1] & op1[XLEN-1]) ? -op1 : op1;
    assign op2_mag   = (md_sel[1] & op2[XLEN-1]) ? -op2 : op2;
    // Remainder follows the dividend; quotient sign is cleared on divide-by-zero to keep all-ones.
    assign neg_next  = (md_sel == MD_REM) ? op1[XLEN-1] :
                       (md_sel == MD_DIV) ? ((op1[XLEN-1] ^ op2[XLEN-1]) & (op2 != '0)) : 1'b0;
    assign md_result = neg_reg ? -md_raw : md_raw;
`else
    assign op1_mag   = op1;
    assign op2_mag   = op2;
    assign md_result = md_raw;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            md_op_reg <= 2'b00;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
`ifdef DLX_EX_SIGNED_MD_EN
            neg_reg   <= 1'b0;
`endif
        end else if (flush_EX) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= BUSY;
                        cnt_reg   <= CW'(XLEN);
                        md_op_reg <= md_sel;
                        a_reg     <= op1_mag;
                        b_reg     <= op2_mag;
                        acc_reg   <= '0;
`ifdef DLX_EX_SIGNED_MD_EN
                        neg_reg   <= neg_next;
`endif
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg - CW'(1);
                    if (md_op_reg == MD_MUL) begin
                        if (a_reg[0])
                            acc_reg <= acc_reg + b_reg;
                        a_reg <= a_reg >> 1;
                        b_reg <= b_reg << 1;
                    end else if (!trial[XLEN]) begin
                        acc_reg <= trial[XLEN-1:0];
                        a_reg   <= {a_reg[XLEN-2:0], 1'b1};
                    end else begin
                        acc_reg <= {acc_reg[XLEN-2:0], a_reg[XLEN-1]};
                        a_reg   <= {a_reg[XLEN-2:0], 1'b0};
                    end
                    if (cnt_reg == CW'(1))
                        state_reg <= DONE;
                end
                DONE: begin
                    if (!hold_MEM)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_MEM          <= 1'b0;
            ALU_out_MEM        <= '0;
            d_write_enable_MEM <= 1'b0;
            d_load_enable_MEM  <= 1'b0;
            Rd_MEM             <= '0;
        end else if (!hold_MEM) begin
            if (flush_EX) begin
                valid_MEM          <= 1'b0;
                d_write_enable_MEM <= 1'b0;
                d_load_enable_MEM  <= 1'b0;
            end else if (state_reg == DONE) begin
                valid_MEM          <= 1'b1;
                ALU_out_MEM        <= md_result;
                d_write_enable_MEM <= d_write_enable_EX;
                d_load_enable_MEM  <= d_load_enable_EX;
                Rd_MEM             <= Rd_EX;
            end else if (stall_EX) begin
                valid_MEM          <= 1'b0;
                d_write_enable_MEM <= 1'b0;
                d_load_enable_MEM  <= 1'b0;
            end else begin
                valid_MEM          <= valid_EX;
                ALU_out_MEM        <= alu_res;
                d_write_enable_MEM <= valid_EX & d_write_enable_EX;
                d_load_enable_MEM  <= valid_EX & d_load_enable_EX;
                Rd_MEM             <= Rd_EX;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage_md.sv
// Self-checking bench for ex_stage_md: directed cases plus random ALU and multiply/divide traffic against a behavioural model.
module tb_ex_stage_md;
    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int OPW  = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            valid_EX;
    logic [OPW-1:0]  I_EX;
    logic [1:0]      md_op_EX, br_EX;
    logic            Pc_alu_EX, Iv_alu_EX, d_write_enable_EX, d_load_enable_EX;
    logic [RW-1:0]   Rd_EX;
    logic [XLEN-1:0] S1_EX, S2_EX, Iv_EX, PC_EX;
    logic            hold_MEM, flush_EX;
    logic            stall_EX, pc_cmd_EX, valid_MEM, d_write_enable_MEM, d_load_enable_MEM;
    logic [XLEN-1:0] pc_in_EX, ALU_out_MEM;
    logic [RW-1:0]   Rd_MEM;

    int total = 0;
    int passed = 0;

    // Expected EX/MEM register contents
    logic            e_valid, e_we, e_le;
    logic [XLEN-1:0] e_out;
    logic [RW-1:0]   e_rd;

    always #5 clk = ~clk;

    ex_stage_md #(.XLEN(XLEN), .RW(RW), .OPW(OPW)) dut (
        .clk(clk), .reset(reset), .valid_EX(valid_EX), .I_EX(I_EX), .md_op_EX(md_op_EX),
        .br_EX(br_EX), .Pc_alu_EX(Pc_alu_EX), .Iv_alu_EX(Iv_alu_EX),
        .d_write_enable_EX(d_write_enable_EX), .d_load_enable_EX(d_load_enable_EX),
        .Rd_EX(Rd_EX), .S1_EX(S1_EX), .S2_EX(S2_EX), .Iv_EX(Iv_EX), .PC_EX(PC_EX),
        .hold_MEM(hold_MEM), .flush_EX(flush_EX), .stall_EX(stall_EX),
        .pc_cmd_EX(pc_cmd_EX), .pc_in_EX(pc_in_EX), .valid_MEM(valid_MEM),
        .ALU_out_MEM(ALU_out_MEM), .d_write_enable_MEM(d_write_enable_MEM),
        .d_load_enable_MEM(d_load_enable_MEM), .Rd_MEM(Rd_MEM)
    );

    function automatic logic [XLEN-1:0] ref_alu(input logic [OPW-1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int sh;
        sh = int'(b % XLEN);
        case (op)
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << sh;
            6: return a >> sh;
            7: return $signed(a) >>> sh;
            8: return ($signed(a) < $signed(b)) ? 1 : 0;
            9: return (a < b) ? 1 : 0;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] ref_md(input logic [1:0] md, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] min_neg, all_ones;
        min_neg  = {1'b1, {(XLEN-1){1'b0}}};
        all_ones = '1;
        case (md)
            2'b01: return a * b;
`ifdef DLX_EX_SIGNED_MD_EN
            2'b10: begin
                if (b == 0) return all_ones;
                if (a == min_neg && b == all_ones) return min_neg;
                return $signed(a) / $signed(b);
            end
            2'b11: begin
                if (b == 0) return a;
                if (a == min_neg && b == all_ones) return 0;
                return $signed(a) % $signed(b);
            end
`else
            2'b10: return (b == 0) ? all_ones : a / b;
            2'b11: return (b == 0) ? a : a % b;
`endif
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_mem(input string tag);
        check({tag, "_valid"}, XLEN'(valid_MEM), XLEN'(e_valid));
        if (e_valid) begin
            check({tag, "_out"}, ALU_out_MEM, e_out);
            check({tag, "_rd"}, XLEN'(Rd_MEM), XLEN'(e_rd));
        end
        check({tag, "_we"}, XLEN'(d_write_enable_MEM), XLEN'(e_we));
        check({tag, "_le"}, XLEN'(d_load_enable_MEM), XLEN'(e_le));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_EX = 0; I_EX = '0; md_op_EX = 0; br_EX = 0; Pc_alu_EX = 0; Iv_alu_EX = 0;
        d_write_enable_EX = 0; d_load_enable_EX = 0; Rd_EX = '0;
        S1_EX = '0; S2_EX = '0; Iv_EX = '0; PC_EX = '0; hold_MEM = 0; flush_EX = 0;
    endtask

    task automatic alu_txn(input logic [OPW-1:0] op, input logic [1:0] md, input logic [1:0] br,
                           input logic pcsel, input logic ivsel, input logic we, input logic le,
                           input logic [RW-1:0] rd, input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2,
                           input logic [XLEN-1:0] iv, input logic [XLEN-1:0] pc,
                           input logic fl, input logic hd);
        logic [XLEN-1:0] a, b, r;
        logic take;
        valid_EX = 1; I_EX = op; md_op_EX = md; br_EX = br; Pc_alu_EX = pcsel; Iv_alu_EX = ivsel;
        d_write_enable_EX = we; d_load_enable_EX = le; Rd_EX = rd;
        S1_EX = s1; S2_EX = s2; Iv_EX = iv; PC_EX = pc; flush_EX = fl; hold_MEM = hd;
        #1;
        a = pcsel ? pc : s1;
        b = ivsel ? iv : s2;
        r = ref_alu(op, a, b);
        take = !fl && (br == 2'b11 || (br == 2'b01 && r == 0) || (br == 2'b10 && r != 0));
        check("alu_stall", XLEN'(stall_EX), XLEN'(1'b0));
        check("br_cmd", XLEN'(pc_cmd_EX), XLEN'(take));
        check("br_target", pc_in_EX, pc + iv);
        tick();
        if (!hd) begin
            if (fl) begin
                e_valid = 0; e_we = 0; e_le = 0;
            end else begin
                e_valid = 1; e_out = r; e_rd = rd; e_we = we; e_le = le;
            end
        end
        check_mem("alu");
        $display("txn alu op=%0d a=%h b=%h res=%h br=%0d take=%0d flush=%0d hold=%0d", op, a, b, r, br, take, fl, hd);
        flush_EX = 0; hold_MEM = 0;
    endtask

    task automatic md_txn(input logic [1:0] md, input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2,
                          input logic [RW-1:0] rd, input int hold_cycles);
        logic [XLEN-1:0] exp;
        int n;
        idle_inputs();
        valid_EX = 1; md_op_EX = md; Rd_EX = rd; S1_EX = s1; S2_EX = s2;
        #1;
        exp = ref_md(md, s1, s2);
        n = 0;
        while (stall_EX === 1'b1 && n < 100) begin
            n++;
            tick();
            e_valid = 0; e_we = 0; e_le = 0;
            check("md_bubble_valid", XLEN'(valid_MEM), XLEN'(1'b0));
            check("md_bubble_we", XLEN'(d_write_enable_MEM), XLEN'(1'b0));
        end
        check("md_stall_cycles", XLEN'(n), XLEN'(XLEN + 1));
        if (hold_cycles > 0) begin
            hold_MEM = 1;
            #1;
            check("md_hold_stall", XLEN'(stall_EX), XLEN'(1'b1));
            repeat (hold_cycles) begin
                tick();
                check("md_hold_stall", XLEN'(stall_EX), XLEN'(1'b1));
                check_mem("md_hold");
            end
            hold_MEM = 0;
            #1;
            check("md_release_stall", XLEN'(stall_EX), XLEN'(1'b0));
        end
        tick();
        e_valid = 1; e_out = exp; e_rd = rd; e_we = 0; e_le = 0;
        check_mem("md_result");
        idle_inputs();
        #1;
        check("md_after_stall", XLEN'(stall_EX), XLEN'(1'b0));
        $display("txn md op=%0d a=%h b=%h res=%h stall_cycles=%0d hold=%0d", md, s1, s2, exp, n, hold_cycles);
    endtask

    initial begin
        int kind, hc;
        logic [XLEN-1:0] r1, r2;
        idle_inputs();
        reset = 1;
        tick(); tick();
        e_valid = 0; e_out = '0; e_rd = '0; e_we = 0; e_le = 0;
        check("rst_valid", XLEN'(valid_MEM), 0);
        check("rst_out", ALU_out_MEM, 0);
        check("rst_rd", XLEN'(Rd_MEM), 0);
        check("rst_we", XLEN'(d_write_enable_MEM), 0);
        check("rst_le", XLEN'(d_load_enable_MEM), 0);
        check("rst_stall", XLEN'(stall_EX), 0);
        check("rst_pc_cmd", XLEN'(pc_cmd_EX), 0);
        reset = 0;
        tick();
        $display("txn reset");

        // ADD 5 + imm 7
        alu_txn(0, 0, 0, 0, 1, 1, 0, 5'd3, 5, 99, 7, 0, 0, 0);
        md_txn(2'b01, 32'h0001_0003, 32'h0000_0010, 5'd4, 0);
        md_txn(2'b10, 100, 7, 5'd5, 0);
        md_txn(2'b11, 100, 7, 5'd6, 0);
        md_txn(2'b10, 9, 0, 5'd7, 0);
        md_txn(2'b11, 9, 0, 5'd8, 0);
        // BNEZ taken / not taken
        alu_txn(1, 0, 2'b10, 0, 0, 0, 0, 5'd9, 5, 3, 32'h20, 32'h100, 0, 0);
        alu_txn(1, 0, 2'b10, 0, 0, 0, 0, 5'd9, 5, 5, 32'h20, 32'h100, 0, 0);
        // Branch on a multiply opcode executes as an ALU op
        alu_txn(0, 2'b01, 2'b11, 0, 0, 1, 1, 5'd10, 2, 3, 32'h8, 32'h40, 0, 0);
        // Flushed and held ALU ops
        alu_txn(0, 0, 0, 0, 0, 1, 1, 5'd11, 1, 1, 0, 0, 1, 0);
        alu_txn(2, 0, 0, 0, 0, 0, 1, 5'd12, 32'hF0, 32'h3C, 0, 0, 0, 0);
        alu_txn(3, 0, 0, 0, 0, 1, 0, 5'd13, 32'hF0, 32'h0F, 0, 0, 0, 1);

        // Flush a division at iteration 10
        idle_inputs();
        valid_EX = 1; md_op_EX = 2'b10; S1_EX = 1000; S2_EX = 3; Rd_EX = 5'd14;
        tick();
        repeat (9) tick();
        flush_EX = 1;
        #1;
        tick();
        idle_inputs();
        #1;
        e_valid = 0; e_we = 0; e_le = 0;
        check("flush_stall", XLEN'(stall_EX), 0);
        check_mem("flush");
        tick(); tick();
        check("flush_no_result", XLEN'(valid_MEM), 0);
        $display("txn md flush at iteration 10");

        // Reset in the middle of a multiply
        alu_txn(0, 0, 0, 0, 0, 1, 0, 5'd15, 40, 2, 0, 0, 0, 0);
        idle_inputs();
        valid_EX = 1; md_op_EX = 2'b01; S1_EX = 123; S2_EX = 456; Rd_EX = 5'd16;
        tick();
        repeat (4) tick();
        reset = 1;
        tick();
        reset = 0;
        idle_inputs();
        #1;
        e_valid = 0; e_out = '0; e_rd = '0; e_we = 0; e_le = 0;
        check("midrst_valid", XLEN'(valid_MEM), 0);
        check("midrst_out", ALU_out_MEM, 0);
        check("midrst_rd", XLEN'(Rd_MEM), 0);
        check("midrst_we", XLEN'(d_write_enable_MEM), 0);
        check("midrst_stall", XLEN'(stall_EX), 0);
        check("midrst_pc_cmd", XLEN'(pc_cmd_EX), 0);
        $display("txn md reset at iteration 5");

        md_txn(2'b01, 32'h0001_0003, 32'h0000_0010, 5'd17, 3);

`ifdef DLX_EX_SIGNED_MD_EN
        md_txn(2'b10, -7, 2, 5'd18, 0);
        md_txn(2'b11, -7, 2, 5'd19, 0);
        md_txn(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 0);
        md_txn(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 0);
        md_txn(2'b10, 9, 0, 5'd22, 0);
        md_txn(2'b11, -9, 0, 5'd23, 0);
`endif

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 4);
            r1 = $urandom;
            r2 = $urandom >> $urandom_range(0, 31);
            if (kind == 0) begin
                if ($urandom_range(0, 3) == 0) r2 = 0;
                hc = $urandom_range(0, 2);
                md_txn(2'($urandom_range(1, 3)), r1, r2, RW'($urandom), hc);
            end else begin
                alu_txn(OPW'($urandom_range(0, 11)), 0, 2'($urandom_range(0, 3)),
                        1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), RW'($urandom),
                        r1, ($urandom_range(0, 3) == 0) ? r1 : r2, $urandom, $urandom,
                        ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
